fixed_dot_acc: RTL and testbench
================================

// Module: fixed_dot_acc
// PURPOSE
//   Streaming dot-product accumulator placed directly downstream of fixed_mul.
//   - Consumes a stream of Q8.8 products over a valid/ready handshake.
//   - Sums LEN consecutive products in a wide signed accumulator.
//   - Emits one saturated Q8.8 result per LEN inputs; one accumulator lane of the matmul datapath.
// PARAMETERS
//   LEN    8   products per dot product; legal range 2..256
//   ACC_W  24  accumulator width in bits, Q(ACC_W-8).8; must satisfy ACC_W >= 16+$clog2(LEN)
// PORTS
//   clk        in   1   rising-edge clock
//   rst        in   1   reset, asynchronous, active-high
//   in_valid   in   1   in_data valid
//   in_ready   out  1   block accepts in_data this cycle
//   in_data    in   16  signed Q8.8 product (fixed_mul result)
//   out_valid  out  1   out_data/out_sat valid
//   out_ready  in   1   consumer accepts result this cycle
//   out_data   out  16  signed Q8.8 dot-product result, saturated
//   out_sat    out  1   1 = result was clamped
// BEHAVIOUR
//   Reset (async, immediate): state=S_IDLE, acc=0, cnt=0, out_valid=0, out_data=0, out_sat=0.
//     in_ready=0 while in reset.
//   Handshakes: a transfer occurs on a clk edge where valid&&ready.
//     Producer holds data stable while valid && !ready.
//     out_valid, out_data and out_sat stay stable until accepted.
//   FSM, all outputs registered or decoded from state only:
//     S_IDLE -> S_ACC unconditionally on the first edge after reset release.
//     S_ACC : in_ready=1, out_valid=0.
//       Each in transfer: acc += sign_extend(in_data, ACC_W); cnt++.
//       Transfer with cnt==LEN-1 -> S_OUT. Register sat(acc+in_data) into out_data, set out_sat.
//       Also clear acc and cnt, so no combinational path from acc to outputs.
//     S_OUT : in_ready=0, out_valid=1.
//       Transfer on out_ready -> S_ACC, out_valid=0 next cycle.
//       out_data and out_sat keep their last values after acceptance.
//   Latency: out_valid asserts the cycle after the LEN-th input transfer.
//     Max throughput: one result per LEN+1 cycles.
//   Input bubbles (in_valid=0) are allowed anywhere and do not change the result.
//   Arithmetic:
//     - Two's-complement accumulation; no intermediate overflow when ACC_W meets the PARAMETERS bound.
//     - sat(): if x > 32767 -> 0x7FFF, out_sat=1; if x < -32768 -> 0x8000, out_sat=1;
//       otherwise x[15:0], out_sat=0.
//     - No rounding; the binary point is unchanged (Q.8 in, Q.8 out).
//   Reset mid-operation discards the partial sum and any pending result.
//     The next output covers only inputs accepted after reset.
//   in_valid while in S_OUT is ignored; in_ready=0, so no transfer occurs.
// CONFIGURATION
//   Macro FIXED_DOT_RELU_EN.
//   Defined:
//     - A saturated result < 0 is replaced by 0x0000 before registering.
//     - out_sat still reports the clamp, so 0x8000 saturation gives out_data=0x0000, out_sat=1.
//   Undefined: no activation; out_data is the saturated signed sum.
//   The macro does not change timing, latency or handshake.
// TESTING (LEN=4, ACC_W=24 unless stated)
//   1 Sum: in 0x0100,0x0200,0x0080,0xFF00 (1,2,0.5,-1) back-to-back
//     -> out_valid 1 cycle after 4th transfer; out_data=0x0280, out_sat=0.
//   2 Bubbles: same data as 1, in_valid low 1-3 cycles between items
//     -> identical result 0x0280; in_ready=1 throughout S_ACC.
//   3 Overflow: four inputs of 0x7FFF -> out_data=0x7FFF, out_sat=1.
//     Four inputs of 0x8000 -> 0x8000, out_sat=1 (0x0000, out_sat=1 with FIXED_DOT_RELU_EN).
//   4 Backpressure: out_ready=0 for 5 cycles while in_valid=1
//     -> out_valid, out_data, out_sat stable; in_ready=0; no input consumed.
//     After out_ready=1, the next 4 inputs form a fresh sum.
//   5 Reset: assert rst after 2 transfers (and separately while in S_OUT)
//     -> out_valid=0, out_data=0 immediately; after release, 1 idle cycle, then 4 new inputs give a correct sum.
//   6 ReLU (macro defined): in 0x0100,0xFE00,0x0000,0x0000 -> out_data=0x0000, out_sat=0.
//     Macro undefined -> 0xFF00.

Source files
------------

// File: rtl/fixed_dot_acc_if.sv
// Handshake bundle for fixed_dot_acc: Q8.8 product stream in, saturated Q8.8 result out.
// The block itself uses the slave modport; the producer/consumer side uses master.
interface fixed_dot_acc_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_sat;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_sat
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_sat
   );
endinterface

// File: rtl/fixed_dot_acc.sv
// Streaming dot-product accumulator: sums LEN Q8.8 products, emits one saturated Q8.8 result.
// Optional macro FIXED_DOT_RELU_EN clamps negative results to zero (out_sat unaffected).
module fixed_dot_acc #(
   parameter int unsigned LEN   = 8,
   parameter int unsigned ACC_W = 24
) (
   input logic           clk,
   input logic           rst,
   fixed_dot_acc_if.slave bus
);

   localparam int unsigned CntW = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(LEN - 1);
   localparam logic signed [ACC_W-1:0] SatMax = ACC_W'(32'sd32767);
   localparam logic signed [ACC_W-1:0] SatMin = ACC_W'(-32'sd32768);

   typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

   state_e                  state_q;
   logic signed [ACC_W-1:0] acc_q;
   logic [CntW-1:0]         cnt_q;
   logic [15:0]             out_data_q;
   logic                    out_sat_q;

   logic signed [ACC_W-1:0] sum;
   logic [15:0]             res_data;
   logic                    res_sat;

   assign sum = acc_q + {{(ACC_W-16){bus.in_data[15]}}, bus.in_data};

   always_comb begin
      res_data = sum[15:0];
      res_sat  = 1'b0;
      if (sum > SatMax) begin
         res_data = 16'h7FFF;
         res_sat  = 1'b1;
      end else if (sum < SatMin) begin
         res_data = 16'h8000;
         res_sat  = 1'b1;
      end
`ifdef FIXED_DOT_RELU_EN
      if (res_data[15]) begin
         res_data = 16'h0000;
      end
`else
`endif
   end

   // Final sum is registered straight into the output so acc never reaches the ports.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         acc_q      <= '0;
         cnt_q      <= '0;
         out_data_q <= '0;
         out_sat_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: state_q <= StAcc;
            StAcc: begin
               if (bus.in_valid) begin
                  if (cnt_q == CntLast) begin
                     out_data_q <= res_data;
                     out_sat_q  <= res_sat;
                     acc_q      <= '0;
                     cnt_q      <= '0;
                     state_q    <= StOut;
                  end else begin
                     acc_q <= sum;
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            StOut: begin
               if (bus.out_ready) begin
                  state_q <= StAcc;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == StAcc);
   assign bus.out_valid = (state_q == StOut);
   assign bus.out_data  = out_data_q;
   assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_fixed_dot_acc.sv
// Self-checking bench for fixed_dot_acc (LEN=4, ACC_W=24): directed cases plus random vectors
// compared against an integer-arithmetic reference of the dot product and saturation rule.
module tb_fixed_dot_acc;

   localparam int Len = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   logic [15:0] vec [Len];

   fixed_dot_acc_if bus ();

   fixed_dot_acc #(.LEN(Len), .ACC_W(24)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer sum of the signed inputs, then clamp to 16 bits.
   function automatic logic [16:0] ref_result();
      int s = 0;
      logic [16:0] r;
      for (int i = 0; i < Len; i++) s += int'($signed(vec[i]));
      if (s > 32767)       r = {1'b1, 16'h7FFF};
      else if (s < -32768) r = {1'b1, 16'h8000};
      else                 r = {1'b0, s[15:0]};
`ifdef FIXED_DOT_RELU_EN
      if (r[15]) r[15:0] = 16'h0000;
`endif
      return r;
   endfunction

   task automatic send(input logic [15:0] d, input int bub);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) check("send_timeout", 32'(bus.in_ready), 32'd1);
      step();
      bus.in_valid = 1'b0;
      bus.in_data  = 16'($urandom);
      for (int b = 0; b < bub; b++) begin
         step();
         check("ready_in_bubble", 32'(bus.in_ready), 32'd1);
      end
   endtask

   task automatic send_items(input int n_items, input int bub_max);
      for (int i = 0; i < n_items; i++)
         send(vec[i], (i == Len - 1) ? 0 : int'($urandom_range(bub_max, 0)));
   endtask

   // Sends vec, checks latency/result, holds backpressure, then accepts.
   task automatic run_dot(input int bub_max, input int hold);
      logic [16:0] exp;
      exp = ref_result();
      send_items(Len, bub_max);
      check("out_valid_latency", 32'(bus.out_valid), 32'd1);
      check("out_data", 32'(bus.out_data), 32'(exp[15:0]));
      check("out_sat", 32'(bus.out_sat), 32'(exp[16]));
      bus.in_valid = 1'b1;
      bus.in_data  = 16'($urandom);
      for (int h = 0; h < hold; h++) begin
         step();
         check("hold_valid", 32'(bus.out_valid), 32'd1);
         check("hold_data", 32'(bus.out_data), 32'(exp[15:0]));
         check("hold_sat", 32'(bus.out_sat), 32'(exp[16]));
         check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check("accept_valid_low", 32'(bus.out_valid), 32'd0);
      check("accept_data_kept", 32'(bus.out_data), 32'(exp[15:0]));
      check("accept_in_ready", 32'(bus.in_ready), 32'd1);
   endtask

   task automatic set_vec(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d);
      vec[0] = a; vec[1] = b; vec[2] = c; vec[3] = d;
   endtask

   task automatic pulse_reset();
      #3 rst = 1'b1;
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      check("rst_out_sat", 32'(bus.out_sat), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      step();
      rst = 1'b0;
      check("idle_in_ready", 32'(bus.in_ready), 32'd0);
      step();
      check("acc_in_ready", 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      logic [7:0] byt;
      bus.in_valid  = 1'b0;
      bus.in_data   = 16'h0000;
      bus.out_ready = 1'b0;
      step();
      step();
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_out_data", 32'(bus.out_data), 32'd0);
      check("reset_out_sat", 32'(bus.out_sat), 32'd0);
      check("reset_in_ready", 32'(bus.in_ready), 32'd0);
      rst = 1'b0;
      check("idle_in_ready", 32'(bus.in_ready), 32'd0);
      step();
      check("acc_in_ready", 32'(bus.in_ready), 32'd1);

      // Plain sum, back-to-back, then with bubbles.
      set_vec(16'h0100, 16'h0200, 16'h0080, 16'hFF00);
      run_dot(0, 0);
      check("sum_value", 32'(bus.out_data), 32'h0280);
      run_dot(3, 0);

      // Saturation both ways.
      set_vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
      run_dot(0, 0);
      set_vec(16'h8000, 16'h8000, 16'h8000, 16'h8000);
      run_dot(1, 0);

      // Backpressure for 5 cycles with in_valid held high, then a fresh sum.
      set_vec(16'h0100, 16'hFE00, 16'h0000, 16'h0000);
      run_dot(0, 5);
      set_vec(16'h0040, 16'h0040, 16'h0040, 16'h0040);
      run_dot(2, 0);
      check("fresh_sum", 32'(bus.out_data), 32'h0100);

      // Reset after two transfers discards the partial sum.
      set_vec(16'h1000, 16'h1000, 16'h0000, 16'h0000);
      send_items(2, 0);
      pulse_reset();
      set_vec(16'h0100, 16'h0200, 16'h0080, 16'hFF00);
      run_dot(0, 0);
      check("post_rst_sum", 32'(bus.out_data), 32'h0280);

      // Reset with a result pending.
      set_vec(16'h0300, 16'h0100, 16'h0000, 16'h0000);
      send_items(Len, 0);
      check("pending_valid", 32'(bus.out_valid), 32'd1);
      pulse_reset();
      set_vec(16'h0001, 16'h0002, 16'h0003, 16'h0004);
      run_dot(1, 0);

      // Random vectors: mix of full-range and small sign-extended values.
      for (int it = 0; it < 16; it++) begin
         for (int i = 0; i < Len; i++) begin
            if ($urandom_range(1, 0) == 1) begin
               vec[i] = 16'($urandom);
            end else begin
               byt    = 8'($urandom);
               vec[i] = {{8{byt[7]}}, byt};
            end
         end
         run_dot(3, int'($urandom_range(3, 0)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
